// File: rtl/arb_2x1_pkg.sv
// Shared types and constants for the 2:1 round-robin arbiter.
// Optional feature macro used across this slice: ARB_2X1_LOCK_EN.
package arb_2x1_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic GRANT_REQ0 = 1'b0;
    localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/arb_2x1_if.sv
// Handshake bundle between two requesters, the arbiter and its consumer.
// ARB_2X1_LOCK_EN adds the lock input alongside the request signals.
interface arb_2x1_if #(
    parameter int unsigned WIDTH = 32
);

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
`ifdef ARB_2X1_LOCK_EN
    logic             lock;
`endif

    // Requesters and consumer side
    modport master (
`ifdef ARB_2X1_LOCK_EN
        output lock,
`endif
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, sel, out_valid, out_data, out_src
    );

    // Arbiter side
    modport slave (
`ifdef ARB_2X1_LOCK_EN
        input  lock,
`endif
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, sel, out_valid, out_data, out_src
    );

endinterface

// File: rtl/arb_2x1_rr.sv
// Round-robin grant selection with last-grant memory.
// With ARB_2X1_LOCK_EN a locked transfer pins the next grant to the same requester.
module arb_2x1_rr
    import arb_2x1_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_valid_i,
    input  logic req1_valid_i,
    input  logic xfer_i,
`ifdef ARB_2X1_LOCK_EN
    input  logic lock_i,
`endif
    output logic grant_o
);

    logic last_grant_q, last_grant_d;
`ifdef ARB_2X1_LOCK_EN
    logic lock_q, lock_d;
`endif

    always_comb begin
        grant_o = last_grant_q;
        if (req0_valid_i && req1_valid_i) begin
            grant_o = ~last_grant_q;
        end else if (req0_valid_i) begin
            grant_o = GRANT_REQ0;
        end else if (req1_valid_i) begin
            grant_o = GRANT_REQ1;
        end
`ifdef ARB_2X1_LOCK_EN
        // A held lock overrides alternation only while the owner still requests
        if (lock_q && ((last_grant_q == GRANT_REQ0) ? req0_valid_i : req1_valid_i)) begin
            grant_o = last_grant_q;
        end
`endif
    end

    always_comb begin
        last_grant_d = last_grant_q;
`ifdef ARB_2X1_LOCK_EN
        lock_d       = lock_q;
`endif
        if (xfer_i) begin
            last_grant_d = grant_o;
`ifdef ARB_2X1_LOCK_EN
            lock_d       = lock_i;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_REQ1;
`ifdef ARB_2X1_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
`ifdef ARB_2X1_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

endmodule

// File: rtl/arb_2x1.sv
// Two-requester arbiter feeding a single registered output slot.
// Build with ARB_2X1_LOCK_EN to add the lock input on the interface.
module arb_2x1
    import arb_2x1_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    arb_2x1_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             grant;
    logic             free;
    logic             xfer;

    arb_2x1_rr u_rr (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (bus.req0_valid),
        .req1_valid_i (bus.req1_valid),
        .xfer_i       (xfer),
`ifdef ARB_2X1_LOCK_EN
        .lock_i       (bus.lock),
`endif
        .grant_o      (grant)
    );

    // Readies are gated by rst so nothing is accepted while reset is held
    assign free           = (state_q == EMPTY) | bus.out_ready;
    assign bus.req0_ready = ~rst & free & (grant == GRANT_REQ0) & bus.req0_valid;
    assign bus.req1_ready = ~rst & free & (grant == GRANT_REQ1) & bus.req1_valid;
    assign xfer           = bus.req0_ready | bus.req1_ready;

    assign bus.sel       = grant;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (!xfer && bus.out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            out_data_d = (grant == GRANT_REQ1) ? bus.req1_data : bus.req0_data;
            out_src_d  = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= GRANT_REQ0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

endmodule

// File: tb/tb_arb_2x1.sv
// Directed self-checking bench for arb_2x1 (lock scenario only with ARB_2X1_LOCK_EN).
module tb_arb_2x1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    arb_2x1_if #(.WIDTH(32)) bus ();

    arb_2x1 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        src_tab [4];
        logic [31:0] dat_tab [4];

        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.out_ready  = 1'b0;
`ifdef ARB_2X1_LOCK_EN
        bus.lock       = 1'b0;
`endif

        // Reset state, with a requester already asserting valid
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_src",   bus.out_src,   0);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);

        // Single transfer, 1-cycle latency
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h0000_00AA;
        bus.out_ready  = 1'b1;
        #1;
        check("single_req0_ready", bus.req0_ready, 1);
        check("single_req1_ready", bus.req1_ready, 0);
        check("single_sel", bus.sel, 0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("single_out_valid", bus.out_valid, 1);
        check("single_out_data",  bus.out_data,  32'h0000_00AA);
        check("single_out_src",   bus.out_src,   0);
        check("idle_sel_hold0",   bus.sel,       0);
        tick();
        check("single_drain", bus.out_valid, 0);

        // Alternation with both requesters valid
        do_reset();
        src_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
        dat_tab = '{32'h11, 32'h22, 32'h11, 32'h22};
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h11;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h22;
        bus.out_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_sel%0d", i), bus.sel, src_tab[i]);
            check($sformatf("rr_ready%0d", i),
                  src_tab[i] ? bus.req1_ready : bus.req0_ready, 1);
            tick();
            check($sformatf("rr_src%0d", i),  bus.out_src,  src_tab[i]);
            check($sformatf("rr_data%0d", i), bus.out_data, dat_tab[i]);
        end

        // Consumer stall: slot holds, no request accepted
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_r0_%0d", i), bus.req0_ready, 0);
            check($sformatf("stall_r1_%0d", i), bus.req1_ready, 0);
            tick();
            check($sformatf("stall_valid%0d", i), bus.out_valid, 1);
            check($sformatf("stall_data%0d", i),  bus.out_data,  32'h22);
            check($sformatf("stall_src%0d", i),   bus.out_src,   1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("resume_r0_ready", bus.req0_ready, 1);
        tick();
        check("resume_src0",  bus.out_src,  0);
        check("resume_data0", bus.out_data, 32'h11);
        tick();
        check("resume_src1",  bus.out_src,  1);
        check("resume_data1", bus.out_data, 32'h22);

        // Only req1 valid: back-to-back, no bubbles
        do_reset();
        bus.req1_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req1_data = 32'h31 + 32'(i);
            #1;
            check($sformatf("solo1_ready%0d", i), bus.req1_ready, 1);
            tick();
            check($sformatf("solo1_valid%0d", i), bus.out_valid, 1);
            check($sformatf("solo1_src%0d", i),   bus.out_src,   1);
            check($sformatf("solo1_data%0d", i),  bus.out_data,  32'h31 + 32'(i));
        end
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b0;
        #1;
        check("idle_sel_hold1", bus.sel, 1);

        // Asynchronous reset while the slot is full
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data",  bus.out_data,  0);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h11;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h22;
        bus.out_ready  = 1'b1;
        #1;
        check("arst_sel", bus.sel, 0);
        check("arst_r0_ready", bus.req0_ready, 1);
        tick();
        check("arst_src", bus.out_src, 0);
        check("arst_data", bus.out_data, 32'h11);

`ifdef ARB_2X1_LOCK_EN
        // Lock holds req0 through its locked transfers, then alternation resumes
        do_reset();
        src_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.lock = (i < 2);
            #1;
            check($sformatf("lock_sel%0d", i), bus.sel, src_tab[i]);
            tick();
            check($sformatf("lock_src%0d", i), bus.out_src, src_tab[i]);
        end
        bus.lock = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arb_2x1.md
ARB_2X1 -- requirements
Module: arb_2x1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of every data port.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 offers data.
REQ-005 The block SHALL have port req0_data  input  WIDTH  requester 0 payload.
REQ-006 The block SHALL have port req0_ready  output  1  requester 0 payload accepted this cycle.
REQ-007 The block SHALL have port req1_valid  input  1  requester 1 offers data.
REQ-008 The block SHALL have port req1_data  input  WIDTH  requester 1 payload.
REQ-009 The block SHALL have port req1_ready  output  1  requester 1 payload accepted this cycle.
REQ-010 The block SHALL have port sel  output  1  combinational grant index, drives the shared 2:1 data select (0 = req0, 1 = req1).
REQ-011 The block SHALL have port out_valid  output  1  registered output slot holds data.
REQ-012 The block SHALL have port out_data  output  WIDTH  registered granted payload.
REQ-013 The block SHALL have port out_src  output  1  index of requester that supplied out_data.
REQ-014 The block SHALL have port out_ready  input  1  consumer accepts out_data.

Function
REQ-015 Transfer on a request side SHALL occur when reqN_valid and reqN_ready are both 1; on the output side when out_valid and out_ready are both 1.
REQ-016 FSM states SHALL be EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on request transfer; FULL->EMPTY on output transfer with no request transfer; FULL->FULL when both occur in the same cycle.
REQ-017 Slot free condition SHALL be free = ~out_valid | out_ready; reqN_ready = free & grant==N & reqN_valid.
REQ-018 Grant SHALL be: only req0 valid -> 0; only req1 valid -> 1; both valid -> requester not equal to last_grant; neither valid -> hold last_grant on sel.
REQ-019 last_grant SHALL update to the granted index on every request transfer only.
REQ-020 On request transfer, out_data, out_src SHALL load next rising edge; latency request-to-out_valid is 1 cycle; throughput 1 transfer/cycle while out_ready=1.
REQ-021 In FULL with out_ready=0, out_data/out_src SHALL hold stable and both reqN_ready SHALL be 0 (no overwrite).
REQ-022 A requester dropping valid without a transfer SHALL not change last_grant or state.

Reset
REQ-023 While rst=1: state EMPTY, out_valid=0, out_data=0, out_src=0, last_grant=1 (req0 wins first contention), req*_ready=0.
REQ-024 Reset asserted mid-transfer SHALL discard the held payload with no output transfer signalled.

Configuration
REQ-025 Macro ARB_2X1_LOCK_EN SHALL, when defined, add port lock  input  1  sampled with a request transfer; if 1, the next grant SHALL go to the same requester whenever it is valid, overriding round-robin until a transfer with lock=0.
REQ-026 Without ARB_2X1_LOCK_EN the lock port SHALL not exist and arbitration SHALL be pure round-robin per REQ-018.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (EMPTY, FULL) and constants GRANT_REQ0=0, GRANT_REQ1=1.
REQ-028 Grant/last_grant logic SHALL be a sub-module arb_2x1_rr; data select and output register stay in arb_2x1.

Verification
REQ-029 Reset then req0_valid=1, req0_data=0x0000_00AA, out_ready=1 -> req0_ready=1 that cycle, next cycle out_valid=1, out_data=0x0000_00AA, out_src=0.
REQ-030 Both valid every cycle, data 0x11/0x22, out_ready=1 -> out_src sequence 0,1,0,1; out_data 0x11,0x22,0x11,0x22.
REQ-031 FULL with out_ready=0 for 3 cycles, both valid -> out_data unchanged, req0_ready=req1_ready=0 all 3 cycles, then resumes alternation.
REQ-032 Only req1 valid for 4 cycles -> 4 back-to-back transfers, out_src=1 each, no bubbles.
REQ-033 rst pulsed while out_valid=1 -> out_valid=0, out_data=0 immediately; next contention grants req0.
REQ-034 With ARB_2X1_LOCK_EN, both valid, lock=1 on first two req0 transfers -> out_src 0,0,0 then 1 after lock=0.
